// File: rtl/tff_bank_arbiter.sv
// tff_bank_arbiter: round-robin arbiter in front of a shared bank of T flip-flops.
// Each winning request toggles one flip-flop, selected by the index that was latched
// when the grant was issued. Each grant lasts exactly one cycle, and busy is the
// state bit of the two-state FSM (IDLE/GRANT).
// Optional build macro: TFF_ARB_ASSERT_EN embeds concurrent assertions.
// Handshake: req is a level. The arbiter samples it only in IDLE. gnt is high for
// exactly one cycle (GRANT). The toggle lands on the edge that ends GRANT. A
// requester drops req while its gnt is high. If req is still high at the next IDLE
// edge, that is treated as a new request.
module tff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int CW   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*$clog2(NFF)-1:0]    req_idx,
  output logic [NREQ-1:0]                gnt,
  output logic [NFF-1:0]                 q,
  output logic [CW-1:0]                  toggle_cnt,
  output logic                           busy
);

  localparam int IW = $clog2(NFF);
  localparam int PW = $clog2(NREQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     lat_w;
  logic [IW-1:0]     lat_idx;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              win_found;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win;
  logic [IW-1:0]     win_idx;
  logic [NREQ-1:0]   win_oh;
  logic [NFF-1:0]    tog_mask;

  // Rotate requests so that bit 0 is the requester the pointer currently favours.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NREQ-1:0];

  // Find the first requester at or after the pointer, then map it back to its absolute index.
  always_comb begin
    win_found = 1'b0;
    win_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, ptr} + (PW+1)'(k);
      end
    end
    if (win_sum >= (PW+1)'(NREQ)) begin
      win_sum = win_sum - (PW+1)'(NREQ);
    end
    win = win_sum[PW-1:0];
  end

  // Select the winner's flip-flop index from the packed index bus.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_idx = req_idx[i*IW +: IW];
      end
    end
  end

  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign tog_mask = {{(NFF-1){1'b0}}, 1'b1} << lat_idx;
  assign busy     = (state == ST_GRANT);

  // Arbitration FSM, flip-flop bank and saturating toggle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      q          <= '0;
      toggle_cnt <= '0;
      ptr        <= '0;
      lat_w      <= '0;
      lat_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            lat_w   <= win;
            lat_idx <= win_idx;
            gnt     <= win_oh;
            state   <= ST_GRANT;
          end else begin
            gnt <= '0;
          end
        end
        ST_GRANT: begin
          q     <= q ^ tog_mask;
          gnt   <= '0;
          ptr   <= (lat_w == PW'(NREQ-1)) ? '0 : lat_w + 1'b1;
          state <= ST_IDLE;
          if (toggle_cnt != {CW{1'b1}}) begin
            toggle_cnt <= toggle_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

`ifdef TFF_ARB_ASSERT_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_gnt_busy: assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> busy);

  a_tog_bit: assert property (@(posedge clk) disable iff (rst)
    (state == ST_GRANT) |=> ((q & $past(tog_mask)) == (~$past(q) & $past(tog_mask))));

  a_others_hold: assert property (@(posedge clk) disable iff (rst)
    (state == ST_GRANT) |=> ((q & ~$past(tog_mask)) == ($past(q) & ~$past(tog_mask))));

  a_idle_hold: assert property (@(posedge clk) disable iff (rst)
    (state == ST_IDLE) |=> (q == $past(q)));

  a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
    1'b1 |=> (toggle_cnt >= $past(toggle_cnt)));
`endif

endmodule
